prio_intc_seq: RTL and testbench
================================

Name: prio_intc_seq

Overview:
- Parametrised, clocked successor to the combinational 27-channel priority interrupt controller.
- Captures per-channel requests into a pending register and arbitrates among enabled pending channels.
- Presents one request (irq_out plus vector id) to the core, then runs an ack / end-of-interrupt handshake.
- Sits between peripheral interrupt lines and the core; in-service blocking is single-level (no nesting).

Parameters:
- NUM_CH, 27, number of interrupt channels (legal range 2..64).
- ID_W, $clog2(NUM_CH), width of the vector id (derived; not overridden).
- EDGE, 1, capture mode: 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  in  1  system clock, rising edge active.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_CH  raw interrupt request lines, synchronous to clk.
- irq_en  in  NUM_CH  per-channel enable (mask); 1 = channel may win arbitration.
- glb_en  in  1  global enable; 0 = no new request is presented.
- irq_ack  in  1  core acknowledges the presented request (one-cycle pulse).
- eoi  in  1  core signals end of service (one-cycle pulse).
- irq_out  out  1  request to the core.
- irq_id  out  ID_W  index of the presented or in-service channel.
- busy  out  1  a channel is in service.
- pending  out  NUM_CH  pending register, visible for debug.

Behaviour:
- Reset (asynchronous, rst_n=0): pending=0, irq_s=0, state=IDLE, irq_out=0, irq_id=0, busy=0. Reset is effective mid-handshake; no request survives it.
- Capture, EDGE=1:
  - irq_s <= irq_in each cycle.
  - pending[i] is set at any edge where irq_in[i]=1 and irq_s[i]=0.
- Capture, EDGE=0: pending[i] is set at any edge where irq_in[i]=1.
- Capture is independent of irq_en and glb_en; masked channels still accumulate pending.
- Clear: pending[irq_id] clears at the edge where the ack is accepted.
- Set/clear collision: if a set and a clear hit the same bit at the same edge, the set wins and the bit stays 1.
- Eligibility: eligible = pending & irq_en.
- Winner: lowest eligible index (channel 0 is highest priority), unless INTC_RR_EN is defined.
- FSM has three states: IDLE, REQ, SERV.
- IDLE:
  - If glb_en=1 and eligible != 0: go to REQ; irq_id <= winner; irq_out <= 1.
  - Otherwise stay in IDLE.
- REQ:
  - irq_id is held stable; a later higher-priority arrival does not preempt the presented id.
  - If irq_ack=1: clear pending[irq_id]; go to SERV; irq_out <= 0; busy <= 1.
  - Otherwise, if glb_en=0 or irq_en[irq_id]=0: withdraw the request. Go to IDLE; irq_out <= 0; pending is untouched.
  - irq_ack takes precedence over withdrawal in the same cycle.
- SERV:
  - irq_id is held.
  - If eoi=1: go to IDLE; busy <= 0.
  - Re-arbitration happens at the earliest on the edge after eoi.
- Stray handshakes: irq_ack in IDLE or SERV and eoi in IDLE or REQ are ignored.
- Latency (EDGE=1): irq_in[i] rises before edge k -> pending[i]=1 after edge k -> irq_out=1 after edge k+1.
- Latency (ack path): irq_ack sampled at edge m -> irq_out=0 and busy=1 after edge m.
- All outputs are registered.

Optional Feature:
- Macro: INTC_RR_EN.
- Defined: round-robin arbitration.
  - A priority pointer rr_ptr (ID_W bits) resets to 0.
  - The winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_CH.
  - On each accepted ack, rr_ptr <= irq_id+1, wrapping to 0 after NUM_CH-1.
- Undefined: no rr_ptr register exists; fixed priority applies, channel 0 highest.

Test Plan:
1. Reset mid-operation: drive channels 0 and 2 pending, reach REQ with irq_id=0, then assert rst_n=0 between edges -> pending, irq_out, irq_id and busy go to 0 immediately, before the next edge.
2. Single channel, EDGE=1: irq_in[5] rises -> pending=0x20 after 1 edge; irq_out=1 and irq_id=5 after 2 edges. Pulse irq_ack -> pending=0, busy=1, irq_out=0. Pulse eoi -> busy=0.
3. Simultaneous arrivals: irq_in[3] and irq_in[7] rise together -> irq_id=3 first. After ack and eoi -> irq_id=7.
4. Masking: irq_en[4]=0 with channel 4 pending -> irq_out stays 0. Set irq_en[4]=1 -> irq_out=1, irq_id=4 one edge later. Drop irq_en[4] while in REQ -> irq_out=0 next edge, pending[4] still 1.
5. Collision, EDGE=0: hold irq_in[2]=1 through the ack -> pending[2] remains 1. After eoi -> re-request with irq_id=2.
6. Arbitration, EDGE=0, irq_in[0] and irq_in[1] held high, repeated ack/eoi cycles:
   - INTC_RR_EN defined -> ids 0,1,0,1.
   - INTC_RR_EN undefined -> ids 0,0,0,0.

Source files
------------

// File: rtl/prio_intc_seq.sv
// rtl/prio_intc_seq.sv - clocked priority interrupt controller with ack/eoi handshake
// Optional macro INTC_RR_EN selects round-robin arbitration instead of fixed priority.
module prio_intc_seq #(
  parameter int NUM_CH = 27,
  parameter int ID_W   = $clog2(NUM_CH),
  parameter bit EDGE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [NUM_CH-1:0] irq_en,
  input  logic              glb_en,
  input  logic              irq_ack,
  input  logic              eoi,
  output logic              irq_out,
  output logic [ID_W-1:0]   irq_id,
  output logic              busy,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] irq_s_q, irq_s_d;
  logic              irq_out_q, irq_out_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;

  logic [NUM_CH-1:0] set_mask, clr_mask, eligible;
  logic [ID_W-1:0]   winner;
  logic              ack_ok;

`ifdef INTC_RR_EN
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              found;
  int                idx;
`endif

  always_comb begin
    irq_s_d  = irq_in;
    set_mask = EDGE ? (irq_in & ~irq_s_q) : irq_in;
    ack_ok   = (state_q == REQ) && irq_ack;
    clr_mask = ack_ok ? (NUM_CH'(1) << irq_id_q) : '0;
    // Set is ORed in after the clear so a same-edge set survives the ack.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    eligible  = pending_q & irq_en;
  end

`ifdef INTC_RR_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (ack_ok) begin
      rr_ptr_d = (int'(irq_id_q) == NUM_CH - 1) ? '0 : irq_id_q + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    // Scan downward so the lowest eligible index is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    irq_out_d = irq_out_q;
    busy_d    = busy_q;
    irq_id_d  = irq_id_q;
    case (state_q)
      IDLE: begin
        if (glb_en && (|eligible)) begin
          state_d   = REQ;
          irq_id_d  = winner;
          irq_out_d = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d   = SERV;
          irq_out_d = 1'b0;
          busy_d    = 1'b1;
        end else if (!glb_en || !irq_en[irq_id_q]) begin
          state_d   = IDLE;
          irq_out_d = 1'b0;
        end
      end
      SERV: begin
        if (eoi) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      irq_s_q   <= '0;
      irq_out_q <= 1'b0;
      busy_q    <= 1'b0;
      irq_id_q  <= '0;
`ifdef INTC_RR_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_s_q   <= irq_s_d;
      irq_out_q <= irq_out_d;
      busy_q    <= busy_d;
      irq_id_q  <= irq_id_d;
`ifdef INTC_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_prio_intc_seq.sv
// tb/tb_prio_intc_seq.sv - directed bench for prio_intc_seq (edge and level instances)
module tb_prio_intc_seq;

  localparam int N  = 27;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_in, irq_en;
  logic          glb_en, irq_ack, eoi;
  logic          irq_out, busy;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;

  logic [N-1:0]  l_irq_in, l_irq_en;
  logic          l_glb_en, l_irq_ack, l_eoi;
  logic          l_irq_out, l_busy;
  logic [IW-1:0] l_irq_id;
  logic [N-1:0]  l_pending;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  prio_intc_seq #(.NUM_CH(N), .EDGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_en(irq_en), .glb_en(glb_en),
    .irq_ack(irq_ack), .eoi(eoi), .irq_out(irq_out), .irq_id(irq_id),
    .busy(busy), .pending(pending)
  );

  prio_intc_seq #(.NUM_CH(N), .EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(l_irq_in), .irq_en(l_irq_en), .glb_en(l_glb_en),
    .irq_ack(l_irq_ack), .eoi(l_eoi), .irq_out(l_irq_out), .irq_id(l_irq_id),
    .busy(l_busy), .pending(l_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_in = '0; irq_en = '1; glb_en = 1'b1; irq_ack = 1'b0; eoi = 1'b0;
    l_irq_in = '0; l_irq_en = '1; l_glb_en = 1'b1; l_irq_ack = 1'b0; l_eoi = 1'b0;
    step();
    step();
    chk("reset_pending", 64'(pending), 64'h0);
    chk("reset_irq_out", 64'(irq_out), 64'h0);
    chk("reset_irq_id", 64'(irq_id), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    irq_in[0] = 1'b1; irq_in[2] = 1'b1;
    step();
    chk("mid_pending", 64'(pending), 64'h5);
    step();
    chk("mid_req_out", 64'(irq_out), 64'h1);
    chk("mid_req_id", 64'(irq_id), 64'h0);
    #2;
    rst_n = 1'b0;
    irq_in = '0;
    #1;
    chk("mid_rst_pending", 64'(pending), 64'h0);
    chk("mid_rst_irq_out", 64'(irq_out), 64'h0);
    chk("mid_rst_irq_id", 64'(irq_id), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    step();
    chk("mid_after_pending", 64'(pending), 64'h0);
  endtask

  task automatic test_single();
    irq_in[5] = 1'b1;
    step();
    chk("single_pending", 64'(pending), 64'h20);
    chk("single_out_early", 64'(irq_out), 64'h0);
    step();
    chk("single_out", 64'(irq_out), 64'h1);
    chk("single_id", 64'(irq_id), 64'h5);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("single_ack_pending", 64'(pending), 64'h0);
    chk("single_ack_busy", 64'(busy), 64'h1);
    chk("single_ack_out", 64'(irq_out), 64'h0);
    step();
    chk("single_serv_id", 64'(irq_id), 64'h5);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("single_eoi_busy", 64'(busy), 64'h0);
    irq_in[5] = 1'b0;
    step();
    chk("single_no_rereq", 64'(irq_out), 64'h0);
  endtask

  task automatic test_simultaneous();
    irq_in[3] = 1'b1; irq_in[7] = 1'b1;
    step();
    step();
    chk("simul_first_out", 64'(irq_out), 64'h1);
    chk("simul_first_id", 64'(irq_id), 64'h3);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("simul_pending", 64'(pending), 64'h80);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    step();
    chk("simul_second_out", 64'(irq_out), 64'h1);
    chk("simul_second_id", 64'(irq_id), 64'h7);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    irq_in = '0;
    step();
    chk("simul_done_pending", 64'(pending), 64'h0);
  endtask

  task automatic test_masking();
    irq_en[4] = 1'b0;
    irq_in[4] = 1'b1;
    step();
    step();
    step();
    chk("mask_out_low", 64'(irq_out), 64'h0);
    chk("mask_pending", 64'(pending[4]), 64'h1);
    irq_en[4] = 1'b1;
    step();
    chk("unmask_out", 64'(irq_out), 64'h1);
    chk("unmask_id", 64'(irq_id), 64'h4);
    irq_en[4] = 1'b0;
    step();
    chk("withdraw_out", 64'(irq_out), 64'h0);
    chk("withdraw_pending", 64'(pending[4]), 64'h1);
    irq_en[4] = 1'b1;
    step();
    chk("rereq_id", 64'(irq_id), 64'h4);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    irq_in = '0;
    chk("mask_done_pending", 64'(pending), 64'h0);
  endtask

  task automatic test_collision();
    l_irq_in[2] = 1'b1;
    step();
    chk("coll_pending", 64'(l_pending[2]), 64'h1);
    step();
    chk("coll_out", 64'(l_irq_out), 64'h1);
    chk("coll_id", 64'(l_irq_id), 64'h2);
    l_irq_ack = 1'b1;
    step();
    l_irq_ack = 1'b0;
    chk("coll_set_wins", 64'(l_pending[2]), 64'h1);
    chk("coll_busy", 64'(l_busy), 64'h1);
    l_eoi = 1'b1;
    step();
    l_eoi = 1'b0;
    chk("coll_eoi_busy", 64'(l_busy), 64'h0);
    step();
    chk("coll_rereq_out", 64'(l_irq_out), 64'h1);
    chk("coll_rereq_id", 64'(l_irq_id), 64'h2);
    l_irq_in = '0;
    l_irq_ack = 1'b1;
    step();
    l_irq_ack = 1'b0;
    chk("coll_cleared", 64'(l_pending), 64'h0);
    l_eoi = 1'b1;
    step();
    l_eoi = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [IW-1:0] exp_id [4];
    bit got;
`ifdef INTC_RR_EN
    exp_id = '{5'd0, 5'd1, 5'd0, 5'd1};
`else
    exp_id = '{5'd0, 5'd0, 5'd0, 5'd0};
`endif
    l_irq_in[0] = 1'b1; l_irq_in[1] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        step();
        if (l_irq_out) got = 1'b1;
      end
      chk($sformatf("arb_req_%0d", r), 64'(got), 64'h1);
      chk($sformatf("arb_id_%0d", r), 64'(l_irq_id), 64'(exp_id[r]));
      l_irq_ack = 1'b1;
      step();
      l_irq_ack = 1'b0;
      l_eoi = 1'b1;
      step();
      l_eoi = 1'b0;
    end
    l_irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_simultaneous();
    test_masking();
    test_collision();
    test_arbitration();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
